// File: rtl/axistream_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is released downstream
// only after its tlast beat arrives. Packets carrying terr on any beat, and
// packets longer than the buffer, are discarded and counted.
// Ports:
//   clk, rst (async, active high)
//   s_axis_*     : upstream slave beat (tdata 8b, tid/tdest/tlast/tkeep/terr)
//   m_axis_*     : downstream master beat (terr tied low)
//   drop_pulse   : one-cycle strobe per dropped packet
//   drop_count   : saturating count of dropped packets
module axistream_pkt_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tid,
  input  logic             s_axis_tdest,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tkeep,
  input  logic             s_axis_terr,
  input  logic [7:0]       s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tid,
  output logic             m_axis_tdest,
  output logic             m_axis_tlast,
  output logic             m_axis_tkeep,
  output logic             m_axis_terr,
  output logic [7:0]       m_axis_tdata,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic {
    S_ACCEPT = 1'b0,
    S_DROP   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_cm_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_wr_nxt;
  logic [PW-1:0] w_cm_nxt;
  logic [PW-1:0] w_wr_inc;
  logic [PW-1:0] w_pkt_len;

  logic r_err_seen;
  logic w_err_nxt;
  logic w_we;
  logic w_drop;
  logic w_full;
  logic w_empty;
  logic w_s_ready;
  logic w_s_acc;
  logic w_m_take;

  logic [11:0] r_mem [DEPTH];
  logic [11:0] w_rd_word;

  logic             r_drop_pulse;
  logic [CNT_W-1:0] r_drop_count;

  assign w_full    = (r_wr_ptr - r_rd_ptr) == P_DEPTH;
  assign w_empty   = r_rd_ptr == r_cm_ptr;
  assign w_wr_inc  = r_wr_ptr + P_ONE;
  // Length of the open packet including the beat being accepted.
  assign w_pkt_len = w_wr_inc - r_cm_ptr;

  // Ready is computed outside the FSM process so acceptance never
  // loops back through the next-state logic.
  assign w_s_ready = !rst && ((r_state == S_DROP) || !w_full);
  assign w_s_acc   = s_axis_tvalid && w_s_ready;
  assign w_m_take  = !w_empty && m_axis_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_ptr;
    w_cm_nxt    = r_cm_ptr;
    w_err_nxt   = r_err_seen;
    w_we        = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_ACCEPT: begin
        if (w_s_acc) begin
          w_we     = 1'b1;
          w_wr_nxt = w_wr_inc;
          if (s_axis_terr) w_err_nxt = 1'b1;
          if (s_axis_tlast) begin
            w_err_nxt = 1'b0;
            if (r_err_seen || s_axis_terr) begin
              w_wr_nxt = r_cm_ptr;
              w_drop   = 1'b1;
            end else begin
              w_cm_nxt = w_wr_inc;
            end
          end else if (w_pkt_len == P_DEPTH) begin
            // Packet cannot fit even in an empty buffer: discard the
            // rest of it without writing.
            w_state_nxt = S_DROP;
            w_wr_nxt    = r_cm_ptr;
            w_err_nxt   = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (w_s_acc && s_axis_tlast) begin
          w_drop      = 1'b1;
          w_state_nxt = S_ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_ACCEPT;
      r_wr_ptr     <= '0;
      r_cm_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err_seen   <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_cm_ptr     <= w_cm_nxt;
      r_err_seen   <= w_err_nxt;
      r_drop_pulse <= w_drop;
      if (w_m_take) r_rd_ptr <= r_rd_ptr + P_ONE;
      if (w_drop && !(&r_drop_count))
        r_drop_count <= r_drop_count + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tid,
                                  s_axis_tdest, s_axis_tlast,
                                  s_axis_tkeep};
  end

  assign w_rd_word = w_empty ? 12'h000 : r_mem[r_rd_ptr[AW-1:0]];

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_rd_word[11:4];
  assign m_axis_tid    = w_rd_word[3];
  assign m_axis_tdest  = w_rd_word[2];
  assign m_axis_tlast  = w_rd_word[1];
  assign m_axis_tkeep  = w_rd_word[0];
  assign m_axis_terr   = 1'b0;
  assign drop_pulse    = r_drop_pulse;
  assign drop_count    = r_drop_count;

endmodule
